// File: rtl/cpu_trace_emitter_pkg.sv
// Shared types, ASCII constants and helpers for the CPU trace emitter.
// Optional macro CPU_TRACE_NEWLINE_EN adds the ST_NL state (trailing '\n' per record).
package cpu_trace_pkg;

    localparam int MAX_TIME = 9999;

    typedef enum logic [4:0] {
        ST_IDLE, ST_CARET, ST_TIME, ST_AT, ST_PC, ST_COLON, ST_SP0, ST_TAG,
        ST_REG, ST_ADDR, ST_SP1, ST_LT, ST_EQ, ST_SP2, ST_DATA, ST_HASH
`ifdef CPU_TRACE_NEWLINE_EN
        , ST_NL
`endif
    } state_t;

`ifdef CPU_TRACE_NEWLINE_EN
    localparam state_t ST_LAST = ST_NL;
`else
    localparam state_t ST_LAST = ST_HASH;
`endif

    localparam logic [7:0] CH_CARET  = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;
    localparam logic [7:0] CH_NL     = 8'h0a;

    // Lowercase hex: 8'h57 + n == 8'h61 + (n - 10) for n >= 10.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

endpackage

// File: rtl/bin2bcd_dec4.sv
// Combinational 14-bit binary to 4-digit BCD (double dabble) plus significant-digit count.
// Inputs above 9999 are outside the range this block can represent.
module bin2bcd_dec4 (
    input  logic [13:0] bin,
    output logic [15:0] bcd,
    output logic [2:0]  ndig
);

    always_comb begin
        // NOTE: blocking assignments are required here -- each shift step reads the
        // value produced by the previous iteration within the same evaluation.
        bcd = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int k = 0; k < 4; k++) begin
                if (bcd[4*k +: 4] >= 4'd5) begin
                    bcd[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
                end
            end
            bcd = {bcd[14:0], bin[i]};
        end

        if (bcd[15:12] != 4'd0)     ndig = 3'd4;
        else if (bcd[11:8] != 4'd0) ndig = 3'd3;
        else if (bcd[7:4] != 4'd0)  ndig = 3'd2;
        else                        ndig = 3'd1;
    end

endmodule

// File: rtl/cpu_trace_emitter.sv
// Serialises one captured register/memory commit record into an ASCII character stream.
// Optional macro CPU_TRACE_NEWLINE_EN appends a newline after '#'.
module cpu_trace_emitter
    import cpu_trace_pkg::*;
#(
    parameter int TIME_W   = 14,
    parameter int MAX_TIME = cpu_trace_pkg::MAX_TIME
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_type,
    input  logic [TIME_W-1:0] req_time,
    input  logic [31:0]       req_pc,
    input  logic [4:0]        req_grf,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_data,
    output logic [7:0]        char,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              frame_done
);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        type_q, type_d;
    logic [13:0] time_q, time_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  grf_q, grf_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  char_q, char_d;
    logic        char_valid_q, char_valid_d;

    logic        accept_beat;
    logic [13:0] bcd_in;
    logic [15:0] bcd;
    logic [2:0]  ndig;

    assign accept_beat = char_valid_q && char_ready;

    // One converter serves both fields: grf only while entering/printing REG.
    assign bcd_in = (state_q == ST_TAG || state_q == ST_REG) ? {9'd0, grf_q} : time_q;

    bin2bcd_dec4 u_bcd (
        .bin  (bcd_in),
        .bcd  (bcd),
        .ndig (ndig)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        type_d  = type_q;
        time_d  = time_q;
        pc_d    = pc_q;
        grf_d   = grf_q;
        addr_d  = addr_q;
        data_d  = data_q;

        if (state_q == ST_IDLE) begin
            if (req_valid) begin
                type_d  = req_type;
                time_d  = (req_time > TIME_W'(MAX_TIME)) ? 14'(MAX_TIME) : 14'(req_time);
                pc_d    = req_pc;
                grf_d   = req_grf;
                addr_d  = req_addr;
                data_d  = req_data;
                state_d = ST_CARET;
            end
        end else if (accept_beat) begin
            case (state_q)
                ST_CARET: begin state_d = ST_TIME; cnt_d = ndig - 3'd1; end
                ST_TIME:  if (cnt_q == 3'd0) state_d = ST_AT; else cnt_d = cnt_q - 3'd1;
                ST_AT:    begin state_d = ST_PC; cnt_d = 3'd7; end
                ST_PC:    if (cnt_q == 3'd0) state_d = ST_COLON; else cnt_d = cnt_q - 3'd1;
                ST_COLON: state_d = ST_SP0;
                ST_SP0:   state_d = ST_TAG;
                ST_TAG: begin
                    if (type_q) begin state_d = ST_ADDR; cnt_d = 3'd7; end
                    else        begin state_d = ST_REG;  cnt_d = ndig - 3'd1; end
                end
                ST_REG, ST_ADDR: if (cnt_q == 3'd0) state_d = ST_SP1; else cnt_d = cnt_q - 3'd1;
                ST_SP1:   state_d = ST_LT;
                ST_LT:    state_d = ST_EQ;
                ST_EQ:    state_d = ST_SP2;
                ST_SP2:   begin state_d = ST_DATA; cnt_d = 3'd7; end
                ST_DATA:  if (cnt_q == 3'd0) state_d = ST_HASH; else cnt_d = cnt_q - 3'd1;
`ifdef CPU_TRACE_NEWLINE_EN
                ST_HASH:  state_d = ST_NL;
                ST_NL:    state_d = ST_IDLE;
`else
                ST_HASH:  state_d = ST_IDLE;
`endif
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // The character is registered, so it is decoded from the state being entered.
    always_comb begin
        char_d = 8'h00;
        case (state_d)
            ST_CARET:        char_d = CH_CARET;
            ST_TIME, ST_REG: char_d = 8'h30 + {4'h0, bcd[{cnt_d[1:0], 2'b00} +: 4]};
            ST_AT:           char_d = CH_AT;
            ST_PC:           char_d = hex_char(pc_q[{cnt_d, 2'b00} +: 4]);
            ST_COLON:        char_d = CH_COLON;
            ST_SP0, ST_SP1, ST_SP2: char_d = CH_SPACE;
            ST_TAG:          char_d = type_q ? CH_STAR : CH_DOLLAR;
            ST_ADDR:         char_d = hex_char(addr_q[{cnt_d, 2'b00} +: 4]);
            ST_LT:           char_d = CH_LT;
            ST_EQ:           char_d = CH_EQ;
            ST_DATA:         char_d = hex_char(data_q[{cnt_d, 2'b00} +: 4]);
            ST_HASH:         char_d = CH_HASH;
`ifdef CPU_TRACE_NEWLINE_EN
            ST_NL:           char_d = CH_NL;
`endif
            default:         char_d = 8'h00;
        endcase
        char_valid_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            type_q       <= 1'b0;
            time_q       <= 14'd0;
            pc_q         <= 32'd0;
            grf_q        <= 5'd0;
            addr_q       <= 32'd0;
            data_q       <= 32'd0;
            char_q       <= 8'h00;
            char_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            type_q       <= type_d;
            time_q       <= time_d;
            pc_q         <= pc_d;
            grf_q        <= grf_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            char_q       <= char_d;
            char_valid_q <= char_valid_d;
        end
    end

    assign char       = char_q;
    assign char_valid = char_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign req_ready  = (state_q == ST_IDLE);
    assign frame_done = accept_beat && (state_q == ST_LAST);

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Scoreboard bench for cpu_trace_emitter: expected characters are queued from a
// $sformatf reference string at request time and compared beat by beat at the output.
module tb_cpu_trace_emitter;
    import cpu_trace_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_type;
    logic [13:0] req_time;
    logic [31:0] req_pc, req_addr, req_data;
    logic [4:0]  req_grf;
    logic [7:0]  char;
    logic        char_valid, char_ready, busy, frame_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    cpu_trace_emitter #(.TIME_W(14), .MAX_TIME(9999)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_time(req_time), .req_pc(req_pc), .req_grf(req_grf),
        .req_addr(req_addr), .req_data(req_data),
        .char(char), .char_valid(char_valid), .char_ready(char_ready),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void push_frame(input logic typ, input int t, input logic [31:0] pc,
                                       input int grf, input logic [31:0] addr, input logic [31:0] data);
        string s;
        int ts;
        ts = (t > 9999) ? 9999 : t;
        if (!typ) s = $sformatf("^%0d@%08h: $%0d <= %08h#", ts, pc, grf, data);
        else      s = $sformatf("^%0d@%08h: *%08h <= %08h#", ts, pc, addr, data);
`ifdef CPU_TRACE_NEWLINE_EN
        s = {s, "\n"};
`endif
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endfunction

    task automatic send_record(input logic typ, input logic [13:0] t, input logic [31:0] pc,
                               input logic [4:0] grf, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (req_ready !== 1'b1) begin
            $display("FAIL req_ready_wait: req_ready=%b expected 1", req_ready);
            errors++;
        end
        req_valid = 1'b1; req_type = typ; req_time = t; req_pc = pc;
        req_grf = grf; req_addr = addr; req_data = data;
        push_frame(typ, int'(t), pc, int'(grf), addr, data);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_type = 1'($urandom); req_time = 14'($urandom); req_pc = $urandom;
        req_grf = 5'($urandom); req_addr = $urandom; req_data = $urandom;
        checks++;
        if (char_valid !== 1'b1 || char !== CH_CARET) begin
            $display("FAIL first_beat: char_valid=%b char=%h expected 1/%h", char_valid, char, CH_CARET);
            errors++;
        end
    endtask

    // max_beats < 0 drains the whole queued frame and then checks the return to idle.
    task automatic receive_frame(input int stall_pct, input int max_beats);
        int beats = 0;
        int cycles = 0;
        logic exp_fd;
        while (exp_q.size() > 0 && beats != max_beats && cycles < 2000) begin
            @(negedge clk);
            cycles++;
            char_ready = ($urandom_range(99) >= stall_pct);
            #1;
            checks++;
            if (char_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0 || char !== exp_q[0]) begin
                $display("FAIL beat%0d: valid=%b busy=%b req_ready=%b char=%h expected 1/1/0/%h (ready=%b)",
                         beats, char_valid, busy, req_ready, char, exp_q[0], char_ready);
                errors++;
            end
            exp_fd = char_ready && (exp_q.size() == 1);
            checks++;
            if (frame_done !== exp_fd) begin
                $display("FAIL frame_done_beat%0d: frame_done=%b expected %b", beats, frame_done, exp_fd);
                errors++;
            end
            if (char_ready) begin
                void'(exp_q.pop_front());
                beats++;
            end
        end
        if (cycles >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d chars left, expected 0", exp_q.size());
            exp_q.delete();
        end else if (exp_q.size() == 0) begin
            @(negedge clk);
            char_ready = 1'b0;
            #1;
            checks++;
            if (req_ready !== 1'b1 || busy !== 1'b0 || char_valid !== 1'b0 || frame_done !== 1'b0) begin
                $display("FAIL end_idle: req_ready=%b busy=%b char_valid=%b frame_done=%b expected 1/0/0/0",
                         req_ready, busy, char_valid, frame_done);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; char_ready = 1'b0;
        req_type = 1'b0; req_time = '0; req_pc = '0; req_grf = '0; req_addr = '0; req_data = '0;
        #12;
        checks++;
        if (char !== 8'h00 || char_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL reset_state: char=%h valid=%b busy=%b done=%b req_ready=%b expected 00/0/0/0/1",
                     char, char_valid, busy, frame_done, req_ready);
            errors++;
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reg_zero();
        send_record(1'b0, 14'd0, 32'h0000_3000, 5'd0, 32'h1111_2222, 32'h0);
        receive_frame(0, -1);
    endtask

    task automatic test_mem_record();
        send_record(1'b1, 14'd1234, 32'h0000_3ffc, 5'd9, 32'h0000_2abc, 32'hdead_beef);
        receive_frame(0, -1);
    endtask

    task automatic test_saturation();
        send_record(1'b0, 14'd10000, 32'h8000_0010, 5'd31, 32'h0, 32'h0123_4567);
        receive_frame(0, -1);
        send_record(1'b0, 14'd42, 32'h0000_abcd, 5'd7, 32'h0, 32'h89ab_cdef);
        receive_frame(0, -1);
    endtask

    task automatic test_stalls();
        send_record(1'b0, 14'd0, 32'h0000_3000, 5'd0, 32'h0, 32'h0);
        receive_frame(50, -1);
    endtask

    task automatic test_mid_reset();
        // '^' + 4 time digits + '@' + 2 pc digits leaves the FSM inside PC.
        send_record(1'b0, 14'd1234, 32'hcafe_f00d, 5'd3, 32'h0, 32'h5555_aaaa);
        receive_frame(0, 8);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1 || char !== 8'h00 || frame_done !== 1'b0) begin
            $display("FAIL mid_reset: valid=%b busy=%b req_ready=%b char=%h done=%b expected 0/0/1/00/0",
                     char_valid, busy, req_ready, char, frame_done);
            errors++;
        end
        exp_q.delete();
        char_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        send_record(1'b1, 14'd77, 32'h0040_0000, 5'd0, 32'hffff_fff0, 32'h0000_0009);
        receive_frame(20, -1);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 4; r++) begin
            send_record(1'($urandom), 14'($urandom_range(12000)), $urandom, 5'($urandom),
                        $urandom, $urandom);
            receive_frame(30, -1);
        end
    endtask

    initial begin
        test_reset();
        test_reg_zero();
        test_mem_record();
        test_saturation();
        test_stalls();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
